btn_tick_conditioner: RTL and testbench

Upstream conditioning stage for the LED shift chain. Takes the raw push-button and the board clock, produces a debounced button level, a single-cycle press pulse, a periodic shift-enable tick, and a held `shift_bit` that the downstream shift register samples on each tick. Replaces the derived 1 Hz clock with a clock-enable tick, so the whole chain runs on one clock.

---
 rtl/btn_tick_conditioner.sv | 156 +++++++++++++++
 tb/tb_btn_tick_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_tick_conditioner.sv
// btn_tick_conditioner: button synchronizer/debouncer, press pulse, periodic
// shift-enable tick and held shift bit. Optional macro: BTN_TICK_PRESS_CNT_EN.
module btn_tick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int TICK_CYCLES     = 125_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       tick,
    output logic       shift_bit,
    output logic [7:0] press_cnt
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TKW = $clog2(TICK_CYCLES);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_HIGH,
        PRESSED,
        DB_LOW
    } state_e;

    state_e           state_q;
    logic             s1_q;
    logic             s2_q;
    logic [DBW-1:0]   db_cnt_q;
    logic             level_q;
    logic             press_q;
    logic [TKW-1:0]   tick_cnt_q;
    logic [TKW-1:0]   tick_cnt_d;
    logic             shift_q;
    logic             tick_w;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with registered level and one-cycle press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q  <= DB_HIGH;
                        db_cnt_q <= '0;
                    end
                end
                DB_HIGH: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DBW'(1);
                    end
                end
                PRESSED: begin
                    if (!s2_q) begin
                        state_q  <= DB_LOW;
                        db_cnt_q <= '0;
                    end
                end
                DB_LOW: begin
                    if (s2_q) begin
                        state_q <= PRESSED;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DBW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Free-running tick counter, wraps at TICK_CYCLES-1
    always_comb begin
        tick_cnt_d = tick_cnt_q + TKW'(1);
        if (tick_cnt_q == TK_LAST) begin
            tick_cnt_d = '0;
        end
    end

    // Tick counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Tick is decoded purely from the counter register
    assign tick_w = (tick_cnt_q == TK_LAST);

    // Shift bit: a press sets it, a tick consumes it; press wins a tie
    // so a press landing on a tick is presented at the following tick
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 1'b0;
        end else if (press_q) begin
            shift_q <= 1'b1;
        end else if (tick_w) begin
            shift_q <= 1'b0;
        end
    end

`ifdef BTN_TICK_PRESS_CNT_EN
    logic [7:0] press_cnt_q;

    // Accepted-press counter, wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt_q <= 8'd0;
        end else if (press_q) begin
            press_cnt_q <= press_cnt_q + 8'd1;
        end
    end

    assign press_cnt = press_cnt_q;
`else
    assign press_cnt = 8'd0;
`endif

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign tick      = tick_w;
    assign shift_bit = shift_q;

endmodule

// File: tb/tb_btn_tick_conditioner.sv
// tb_btn_tick_conditioner: directed bench for btn_tick_conditioner
// with DEBOUNCE_CYCLES=4 and TICK_CYCLES=16.
module tb_btn_tick_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       btn_press;
    logic       tick;
    logic       shift_bit;
    logic [7:0] press_cnt;

    int checks;
    int errors;

    btn_tick_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .tick(tick),
        .shift_bit(shift_bit),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n edges; the next edge after return is edge 1
    task automatic do_reset(input int n);
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL reset_level: got %b expected 0", btn_level);
        end
        checks++;
        if (btn_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_press: got %b expected 0", btn_press);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b expected 0", tick);
        end
        checks++;
        if (shift_bit !== 1'b0) begin
            errors++;
            $display("FAIL reset_shift: got %b expected 0", shift_bit);
        end
        checks++;
        if (press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", press_cnt);
        end
    endtask

    // Clean press from edge 1, held; also covers tick timing and shift bit
    task automatic test_clean_press_tick();
        logic e_lvl, e_prs, e_tck, e_sft;
        do_reset(2);
        btn_in = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            e_lvl = (k >= 7);
            e_prs = (k == 7);
            e_tck = (k == 15) || (k == 31);
            e_sft = (k >= 8) && (k <= 15);
            checks++;
            if (btn_level !== e_lvl) begin
                errors++;
                $display("FAIL clean_level edge %0d: got %b expected %b",
                         k, btn_level, e_lvl);
            end
            checks++;
            if (btn_press !== e_prs) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %b expected %b",
                         k, btn_press, e_prs);
            end
            checks++;
            if (tick !== e_tck) begin
                errors++;
                $display("FAIL tick edge %0d: got %b expected %b",
                         k, tick, e_tck);
            end
            checks++;
            if (shift_bit !== e_sft) begin
                errors++;
                $display("FAIL shift edge %0d: got %b expected %b",
                         k, shift_bit, e_sft);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        do_reset(2);
        pat = 6'b100110;
        for (int k = 1; k <= 16; k++) begin
            btn_in = (k <= 6) ? pat[6-k] : 1'b0;
            step();
            checks++;
            if (btn_level !== 1'b0 || btn_press !== 1'b0) begin
                errors++;
                $display("FAIL bounce_high edge %0d: got lvl=%b prs=%b expected 0/0",
                         k, btn_level, btn_press);
            end
        end
        btn_in = 1'b1;
        repeat (10) step();
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL bounce_setup_level: got %b expected 1", btn_level);
        end
        pat = 6'b011001;
        for (int k = 1; k <= 16; k++) begin
            btn_in = (k <= 6) ? pat[6-k] : 1'b1;
            step();
            checks++;
            if (btn_level !== 1'b1 || btn_press !== 1'b0) begin
                errors++;
                $display("FAIL bounce_low edge %0d: got lvl=%b prs=%b expected 1/0",
                         k, btn_level, btn_press);
            end
        end
    endtask

    // Press accepted exactly in the tick cycle after edge 31
    task automatic test_press_on_tick();
        do_reset(2);
        for (int k = 1; k <= 48; k++) begin
            btn_in = (k >= 25);
            step();
            if (k == 31) begin
                checks++;
                if (btn_press !== 1'b1 || tick !== 1'b1 || shift_bit !== 1'b0) begin
                    errors++;
                    $display("FAIL coincide_31: got prs=%b tck=%b sft=%b expected 1/1/0",
                             btn_press, tick, shift_bit);
                end
            end
            if (k == 32) begin
                checks++;
                if (shift_bit !== 1'b1 || tick !== 1'b0) begin
                    errors++;
                    $display("FAIL coincide_32: got sft=%b tck=%b expected 1/0",
                             shift_bit, tick);
                end
            end
            if (k == 47) begin
                checks++;
                if (shift_bit !== 1'b1 || tick !== 1'b1) begin
                    errors++;
                    $display("FAIL coincide_47: got sft=%b tck=%b expected 1/1",
                             shift_bit, tick);
                end
            end
            if (k == 48) begin
                checks++;
                if (shift_bit !== 1'b0) begin
                    errors++;
                    $display("FAIL coincide_48: got sft=%b expected 0", shift_bit);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e_lvl, e_prs;
        do_reset(2);
        btn_in = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (btn_level !== 1'b0 || btn_press !== 1'b0 ||
            tick !== 1'b0 || shift_bit !== 1'b0 || press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outs: got lvl=%b prs=%b tck=%b sft=%b cnt=%0d expected all 0",
                     btn_level, btn_press, tick, shift_bit, press_cnt);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            e_lvl = (k >= 7);
            e_prs = (k == 7);
            checks++;
            if (btn_level !== e_lvl || btn_press !== e_prs) begin
                errors++;
                $display("FAIL midrst_press edge %0d: got lvl=%b prs=%b expected %b/%b",
                         k, btn_level, btn_press, e_lvl, e_prs);
            end
        end
    endtask

    task automatic press_once();
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_counter();
        logic [7:0] e3, e255, e256;
`ifdef BTN_TICK_PRESS_CNT_EN
        e3   = 8'd3;
        e255 = 8'd255;
        e256 = 8'd0;
`else
        e3   = 8'd0;
        e255 = 8'd0;
        e256 = 8'd0;
`endif
        do_reset(2);
        repeat (3) press_once();
        checks++;
        if (press_cnt !== e3) begin
            errors++;
            $display("FAIL cnt_3: got %0d expected %0d", press_cnt, e3);
        end
        repeat (252) press_once();
        checks++;
        if (press_cnt !== e255) begin
            errors++;
            $display("FAIL cnt_255: got %0d expected %0d", press_cnt, e255);
        end
        press_once();
        checks++;
        if (press_cnt !== e256) begin
            errors++;
            $display("FAIL cnt_256: got %0d expected %0d", press_cnt, e256);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_clean_press_tick();
        test_bounce();
        test_press_on_tick();
        test_reset_mid();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
